// File: rtl/ctrl_decode_pipe_if.sv
// Bundles the D-stage decode inputs and E-stage control outputs of ctrl_decode_pipe.
// Latency: none, this is wiring only.
// Backpressure: stall_o travels back to fetch/decode on this bundle.
interface ctrl_decode_pipe_if #(
   parameter int WB_DEPTH = 2
);
   // D-stage instruction fields and hazard-unit controls
   logic                    instr_valid_i;
   logic [6:0]              opcode;
   logic [2:0]              funct3;
   logic [6:0]              funct7;
   logic [4:0]              rd_i;
   logic                    stall_i;
   logic                    flush_i;

   // E-stage control bundle
   logic                    validE;
   logic                    RegWriteE;
   logic                    MemWriteE;
   logic                    PCBranchE;
   logic                    MemtoRegE;
   logic                    JALRctrlE;
   logic [4:0]              ALUopE;
   logic [2:0]              immSelE;
   logic [2:0]              strCtrlE;
   logic [1:0]              SrcASelE;
   logic [1:0]              SrcBSelE;
   logic [4:0]              rdE;
   logic                    illegalE;

   // MUL/DIV sequencing and in-flight destination history
   logic                    stall_o;
   logic                    md_done_o;
   logic [WB_DEPTH-1:0]     regwrite_pipe_o;
   logic [5*WB_DEPTH-1:0]   rd_pipe_o;

   // Decode pipe side
   modport master (
      input  instr_valid_i, opcode, funct3, funct7, rd_i, stall_i, flush_i,
      output validE, RegWriteE, MemWriteE, PCBranchE, MemtoRegE, JALRctrlE,
      output ALUopE, immSelE, strCtrlE, SrcASelE, SrcBSelE, rdE, illegalE,
      output stall_o, md_done_o, regwrite_pipe_o, rd_pipe_o
   );

   // Fetch/decode and hazard-unit side
   modport slave (
      output instr_valid_i, opcode, funct3, funct7, rd_i, stall_i, flush_i,
      input  validE, RegWriteE, MemWriteE, PCBranchE, MemtoRegE, JALRctrlE,
      input  ALUopE, immSelE, strCtrlE, SrcASelE, SrcBSelE, rdE, illegalE,
      input  stall_o, md_done_o, regwrite_pipe_o, rd_pipe_o
   );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// RV32I(+M) control decode in D, registered into E, with MUL/DIV occupancy FSM and rd history.
// Latency: 1 cycle D->E; history stage k is E+1+k; MUL/DIV holds E for MULDIV_LAT cycles.
// Backpressure: E holds on stall_i or stall_o; stall_o is high while a MUL/DIV still has cycles left.
module ctrl_decode_pipe #(
   parameter bit EN_MULDIV  = 1'b1,
   parameter int MULDIV_LAT = 4,
   parameter int WB_DEPTH   = 2
) (
   input logic                 clk,
   input logic                 rst,
   ctrl_decode_pipe_if.master  bus
);
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ALUREG = 7'b0110011;
   localparam logic [6:0] OP_ALUIMM = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

   typedef struct packed {
      logic       valid;
      logic       regWrite;
      logic       memWrite;
      logic       pcBranch;
      logic       memtoReg;
      logic       jalrCtrl;
      logic [4:0] aluOp;
      logic [2:0] immSel;
      logic [2:0] strCtrl;
      logic [1:0] srcASel;
      logic [1:0] srcBSel;
      logic [4:0] rd;
      logic       illegal;
   } ctrlE_t;

   // Bubble: the values an empty E stage presents (no side effects, neutral selects)
   localparam ctrlE_t BUBBLE = '{valid: 1'b0, regWrite: 1'b0, memWrite: 1'b0, pcBranch: 1'b0,
                                 memtoReg: 1'b0, jalrCtrl: 1'b1, aluOp: 5'd0, immSel: 3'd6,
                                 strCtrl: 3'd0, srcASel: 2'b11, srcBSel: 2'b00, rd: 5'd0,
                                 illegal: 1'b0};

   typedef enum logic {IDLE, BUSY} mdState_t;

   ctrlE_t     dec;
   ctrlE_t     eReg;
   logic       isMop;
   mdState_t   mdState;
   logic [3:0] mdCnt;
   logic       stallReg;
   logic       doneReg;
   logic       hold;
   logic       eAdvance;
   logic       mLoad;
   logic [WB_DEPTH-1:0]   rwHist;
   logic [5*WB_DEPTH-1:0] rdHist;

   assign hold     = bus.stall_i | stallReg;
   assign eAdvance = ~bus.flush_i & ~hold;
   assign mLoad    = eAdvance & bus.instr_valid_i & isMop;

   // D-stage decode: start from a bubble and fill in the fields each opcode uses
   always_comb begin
      dec         = BUBBLE;
      dec.valid   = bus.instr_valid_i;
      dec.strCtrl = bus.funct3;
      dec.rd      = bus.rd_i;
      isMop       = 1'b0;
      case (bus.opcode)
         OP_LOAD: begin
            dec.srcBSel  = 2'd1;
            dec.memtoReg = 1'b1;
            dec.immSel   = 3'd5;
            dec.regWrite = 1'b1;
         end
         OP_STORE: begin
            dec.srcBSel  = 2'd1;
            dec.memWrite = 1'b1;
            dec.immSel   = 3'd2;
         end
         OP_ALUREG: begin
            dec.regWrite = 1'b1;
            if (EN_MULDIV && (bus.funct7 == 7'b0000001)) begin
               isMop     = 1'b1;
               dec.aluOp = {1'b1, 1'b0, bus.funct3};
            end else begin
               dec.aluOp = {1'b0, bus.funct7[5], bus.funct3};
            end
         end
         OP_ALUIMM: begin
            dec.srcBSel  = 2'd1;
            dec.immSel   = 3'd0;
            dec.regWrite = 1'b1;
            dec.aluOp    = {2'b00, bus.funct3};
         end
         OP_BRANCH: begin
            dec.pcBranch = 1'b1;
            dec.immSel   = 3'd3;
            dec.aluOp    = {2'b00, bus.funct3};
         end
         OP_JAL: begin
            dec.srcBSel  = 2'd2;
            dec.srcASel  = 2'b00;
            dec.pcBranch = 1'b1;
            dec.immSel   = 3'd4;
            dec.regWrite = 1'b1;
            dec.aluOp    = 5'b01000;
         end
         OP_JALR: begin
            dec.srcBSel  = 2'd2;
            dec.srcASel  = 2'b00;
            dec.pcBranch = 1'b1;
            dec.jalrCtrl = 1'b0;
            dec.immSel   = 3'd0;
            dec.regWrite = 1'b1;
            dec.aluOp    = 5'b01000;
         end
         OP_LUI: begin
            dec.srcBSel  = 2'd1;
            dec.srcASel  = 2'b01;
            dec.immSel   = 3'd1;
            dec.regWrite = 1'b1;
         end
         OP_AUIPC: begin
            dec.srcBSel  = 2'd1;
            dec.srcASel  = 2'b00;
            dec.immSel   = 3'd1;
            dec.regWrite = 1'b1;
         end
         default: begin
            // Undecodable: bubble controls keep RegWrite/MemWrite/PCBranch low
            dec.illegal = bus.instr_valid_i;
         end
      endcase
      // Writes to x0 are architecturally discarded, so don't advertise them to forwarding
      if (bus.rd_i == 5'd0) begin
         dec.regWrite = 1'b0;
      end
   end

   // E-stage register: flush beats hold beats load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eReg <= BUBBLE;
      end else if (bus.flush_i) begin
         eReg <= BUBBLE;
      end else if (!hold) begin
         eReg <= dec;
      end
   end

   // MUL/DIV occupancy FSM; stall_o and md_done_o are registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mdState  <= IDLE;
         mdCnt    <= 4'd0;
         stallReg <= 1'b0;
         doneReg  <= 1'b0;
      end else if (bus.flush_i) begin
         mdState  <= IDLE;
         mdCnt    <= 4'd0;
         stallReg <= 1'b0;
         doneReg  <= 1'b0;
      end else if ((mdState == BUSY) && (mdCnt != 4'd0)) begin
         // Counting continues under stall_i so the result time is fixed
         mdCnt    <= mdCnt - 4'd1;
         stallReg <= (mdCnt != 4'd1);
         doneReg  <= (mdCnt == 4'd1);
      end else if (mLoad) begin
         mdState  <= BUSY;
         mdCnt    <= LAT_M1;
         stallReg <= (LAT_M1 != 4'd0);
         doneReg  <= (LAT_M1 == 4'd0);
      end else if ((mdState == BUSY) && bus.stall_i) begin
         // Finished but E is frozen externally: keep reporting done until it leaves
         mdState  <= BUSY;
         mdCnt    <= 4'd0;
         stallReg <= 1'b0;
         doneReg  <= 1'b1;
      end else begin
         mdState  <= IDLE;
         mdCnt    <= 4'd0;
         stallReg <= 1'b0;
         doneReg  <= 1'b0;
      end
   end

   // Post-E (RegWrite, rd) history; bubbles enter whenever E does not advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rwHist <= '0;
         rdHist <= '0;
      end else begin
         rwHist[0]   <= eAdvance & eReg.regWrite & eReg.valid;
         rdHist[4:0] <= eAdvance ? eReg.rd : 5'd0;
         for (int k = 1; k < WB_DEPTH; k++) begin
            rwHist[k]        <= rwHist[k-1];
            rdHist[5*k +: 5] <= rdHist[5*(k-1) +: 5];
         end
      end
   end

   assign bus.validE          = eReg.valid;
   assign bus.RegWriteE       = eReg.regWrite;
   assign bus.MemWriteE       = eReg.memWrite;
   assign bus.PCBranchE       = eReg.pcBranch;
   assign bus.MemtoRegE       = eReg.memtoReg;
   assign bus.JALRctrlE       = eReg.jalrCtrl;
   assign bus.ALUopE          = eReg.aluOp;
   assign bus.immSelE         = eReg.immSel;
   assign bus.strCtrlE        = eReg.strCtrl;
   assign bus.SrcASelE        = eReg.srcASel;
   assign bus.SrcBSelE        = eReg.srcBSel;
   assign bus.rdE             = eReg.rd;
   assign bus.illegalE        = eReg.illegal;
   assign bus.stall_o         = stallReg;
   assign bus.md_done_o       = doneReg;
   assign bus.regwrite_pipe_o = rwHist;
   assign bus.rd_pipe_o       = rdHist;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: default build, EN_MULDIV=0 build and MULDIV_LAT=1 build.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall_i/flush_i driven directly; stall_o observed.
module tb_ctrl_decode_pipe;
   logic clk;
   logic rst;

   logic       instrValid;
   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rdIn;
   logic       stallIn;
   logic       flushIn;

   int nCompared = 0;
   int nMismatch = 0;

   ctrl_decode_pipe_if #(.WB_DEPTH(2)) ifA ();
   ctrl_decode_pipe_if #(.WB_DEPTH(2)) ifB ();
   ctrl_decode_pipe_if #(.WB_DEPTH(2)) ifC ();

   ctrl_decode_pipe #(.EN_MULDIV(1'b1), .MULDIV_LAT(4), .WB_DEPTH(2)) dutA (.clk(clk), .rst(rst), .bus(ifA));
   ctrl_decode_pipe #(.EN_MULDIV(1'b0), .MULDIV_LAT(4), .WB_DEPTH(2)) dutB (.clk(clk), .rst(rst), .bus(ifB));
   ctrl_decode_pipe #(.EN_MULDIV(1'b1), .MULDIV_LAT(1), .WB_DEPTH(2)) dutC (.clk(clk), .rst(rst), .bus(ifC));

   assign ifA.instr_valid_i = instrValid;
   assign ifA.opcode        = opc;
   assign ifA.funct3        = f3;
   assign ifA.funct7        = f7;
   assign ifA.rd_i          = rdIn;
   assign ifA.stall_i       = stallIn;
   assign ifA.flush_i       = flushIn;
   assign ifB.instr_valid_i = instrValid;
   assign ifB.opcode        = opc;
   assign ifB.funct3        = f3;
   assign ifB.funct7        = f7;
   assign ifB.rd_i          = rdIn;
   assign ifB.stall_i       = stallIn;
   assign ifB.flush_i       = flushIn;
   assign ifC.instr_valid_i = instrValid;
   assign ifC.opcode        = opc;
   assign ifC.funct3        = f3;
   assign ifC.funct7        = f7;
   assign ifC.rd_i          = rdIn;
   assign ifC.stall_i       = stallIn;
   assign ifC.flush_i       = flushIn;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatch++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] fn3,
                        input logic [6:0] fn7, input logic [4:0] rd);
      instrValid = v;
      opc        = op;
      f3         = fn3;
      f7         = fn7;
      rdIn       = rd;
   endtask

   task automatic idle();
      drive(1'b0, 7'd0, 3'd0, 7'd0, 5'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b1;
      stallIn = 1'b0;
      flushIn = 1'b0;
      idle();
      tick();
      tick();

      // Reset state
      chk("rst_validE",   32'(ifA.validE),          0);
      chk("rst_jalr",     32'(ifA.JALRctrlE),       1);
      chk("rst_immSel",   32'(ifA.immSelE),         6);
      chk("rst_srcA",     32'(ifA.SrcASelE),        3);
      chk("rst_stall",    32'(ifA.stall_o),         0);
      chk("rst_done",     32'(ifA.md_done_o),       0);
      chk("rst_rwpipe",   32'(ifA.regwrite_pipe_o), 0);
      chk("rst_rdpipe",   32'(ifA.rd_pipe_o),       0);
      rst = 1'b0;

      // ADDI x5
      drive(1'b1, 7'b0010011, 3'd0, 7'd0, 5'd5);
      tick();
      chk("addi_validE", 32'(ifA.validE),    1);
      chk("addi_rw",     32'(ifA.RegWriteE), 1);
      chk("addi_aluop",  32'(ifA.ALUopE),    0);
      chk("addi_srcB",   32'(ifA.SrcBSelE),  1);
      chk("addi_immSel", 32'(ifA.immSelE),   0);
      chk("addi_rdE",    32'(ifA.rdE),       5);
      idle();
      tick();
      chk("addi_hist0_rw", 32'(ifA.regwrite_pipe_o), 32'b01);
      chk("addi_hist0_rd", 32'(ifA.rd_pipe_o),       32'(10'b00000_00101));
      tick();
      chk("addi_hist1_rw", 32'(ifA.regwrite_pipe_o), 32'b10);
      chk("addi_hist1_rd", 32'(ifA.rd_pipe_o),       32'(10'b00101_00000));

      // JAL rd=1, then JAL rd=0
      drive(1'b1, 7'b1101111, 3'd0, 7'd0, 5'd1);
      tick();
      chk("jal_rw",     32'(ifA.RegWriteE), 1);
      chk("jal_pcb",    32'(ifA.PCBranchE), 1);
      chk("jal_aluop",  32'(ifA.ALUopE),    32'b01000);
      chk("jal_srcA",   32'(ifA.SrcASelE),  0);
      chk("jal_srcB",   32'(ifA.SrcBSelE),  2);
      chk("jal_immSel", 32'(ifA.immSelE),   4);
      chk("jal_jalr",   32'(ifA.JALRctrlE), 1);
      drive(1'b1, 7'b1101111, 3'd0, 7'd0, 5'd0);
      tick();
      chk("jalx0_rw",  32'(ifA.RegWriteE), 0);
      chk("jalx0_pcb", 32'(ifA.PCBranchE), 1);

      // JALR, Store, Load, LUI, Branch, SUB
      drive(1'b1, 7'b1100111, 3'd0, 7'd0, 5'd3);
      tick();
      chk("jalr_jalr",   32'(ifA.JALRctrlE), 0);
      chk("jalr_immSel", 32'(ifA.immSelE),   0);
      drive(1'b1, 7'b0100011, 3'd2, 7'd0, 5'd4);
      tick();
      chk("sw_mw",     32'(ifA.MemWriteE), 1);
      chk("sw_rw",     32'(ifA.RegWriteE), 0);
      chk("sw_immSel", 32'(ifA.immSelE),   2);
      chk("sw_str",    32'(ifA.strCtrlE),  2);
      drive(1'b1, 7'b0000011, 3'd4, 7'd0, 5'd6);
      tick();
      chk("lw_m2r",    32'(ifA.MemtoRegE), 1);
      chk("lw_immSel", 32'(ifA.immSelE),   5);
      chk("lw_srcB",   32'(ifA.SrcBSelE),  1);
      drive(1'b1, 7'b0110111, 3'd0, 7'd0, 5'd2);
      tick();
      chk("lui_srcA",   32'(ifA.SrcASelE), 1);
      chk("lui_immSel", 32'(ifA.immSelE),  1);
      drive(1'b1, 7'b1100011, 3'd1, 7'd0, 5'd0);
      tick();
      chk("bne_aluop",  32'(ifA.ALUopE),   32'b00001);
      chk("bne_immSel", 32'(ifA.immSelE),  3);
      chk("bne_srcA",   32'(ifA.SrcASelE), 3);
      drive(1'b1, 7'b0110011, 3'd0, 7'b0100000, 5'd8);
      tick();
      chk("sub_aluop",  32'(ifA.ALUopE),   32'b01000);
      chk("sub_rw",     32'(ifA.RegWriteE), 1);
      idle();
      tick();
      tick();

      // MUL x7, latency 4
      drive(1'b1, 7'b0110011, 3'd0, 7'b0000001, 5'd7);
      tick();
      chk("mul_aluop",  32'(ifA.ALUopE),    32'b10000);
      chk("mul_st1",    32'(ifA.stall_o),   1);
      chk("mul_dn1",    32'(ifA.md_done_o), 0);
      chk("m0_aluop",   32'(ifB.ALUopE),    0);
      chk("m0_stall",   32'(ifB.stall_o),   0);
      chk("l1_stall",   32'(ifC.stall_o),   0);
      chk("l1_done",    32'(ifC.md_done_o), 1);
      drive(1'b1, 7'b0010011, 3'd0, 7'd0, 5'd9);
      tick();
      chk("mul_st2",    32'(ifA.stall_o),   1);
      chk("mul_hold",   32'(ifA.rdE),       7);
      chk("mul_bub2",   32'(ifA.regwrite_pipe_o), 0);
      chk("m0_adv",     32'(ifB.rdE),       9);
      chk("l1_adv",     32'(ifC.rdE),       9);
      chk("l1_done2",   32'(ifC.md_done_o), 0);
      tick();
      chk("mul_st3",    32'(ifA.stall_o),   1);
      chk("mul_dn3",    32'(ifA.md_done_o), 0);
      chk("mul_bub3",   32'(ifA.regwrite_pipe_o), 0);
      tick();
      chk("mul_st4",    32'(ifA.stall_o),   0);
      chk("mul_dn4",    32'(ifA.md_done_o), 1);
      chk("mul_rd4",    32'(ifA.rdE),       7);
      tick();
      chk("mul_dn5",    32'(ifA.md_done_o), 0);
      chk("mul_next",   32'(ifA.rdE),       9);
      chk("mul_hist_rw", 32'(ifA.regwrite_pipe_o), 32'b01);
      chk("mul_hist_rd", 32'(ifA.rd_pipe_o),       32'(10'b00000_00111));
      idle();
      tick();

      // MUL then flush in its second cycle
      drive(1'b1, 7'b0110011, 3'd0, 7'b0000001, 5'd8);
      tick();
      chk("mfl_st1", 32'(ifA.stall_o), 1);
      idle();
      flushIn = 1'b1;
      tick();
      flushIn = 1'b0;
      chk("mfl_valid", 32'(ifA.validE),    0);
      chk("mfl_st2",   32'(ifA.stall_o),   0);
      chk("mfl_dn2",   32'(ifA.md_done_o), 0);
      tick();
      chk("mfl_dn3",   32'(ifA.md_done_o), 0);
      chk("mfl_st3",   32'(ifA.stall_o),   0);
      tick();
      chk("mfl_dn4",   32'(ifA.md_done_o), 0);

      // MUL with stall_i held past completion, then back-to-back MUL
      drive(1'b1, 7'b0110011, 3'd0, 7'b0000001, 5'd10);
      tick();
      idle();
      stallIn = 1'b1;
      tick();
      tick();
      tick();
      chk("mst_dn",   32'(ifA.md_done_o), 1);
      tick();
      chk("mst_dnh",  32'(ifA.md_done_o), 1);
      chk("mst_sth",  32'(ifA.stall_o),   0);
      chk("mst_rdh",  32'(ifA.rdE),       10);
      stallIn = 1'b0;
      drive(1'b1, 7'b0110011, 3'd1, 7'b0000001, 5'd11);
      tick();
      chk("mb2b_st",  32'(ifA.stall_o),   1);
      chk("mb2b_dn",  32'(ifA.md_done_o), 0);
      chk("mb2b_rd",  32'(ifA.rdE),       11);
      chk("mb2b_op",  32'(ifA.ALUopE),    32'b10001);
      chk("mb2b_hrw", 32'(ifA.regwrite_pipe_o), 32'b01);
      chk("mb2b_hrd", 32'(ifA.rd_pipe_o),       32'(10'b00000_01010));
      idle();
      flushIn = 1'b1;
      tick();
      flushIn = 1'b0;
      chk("mb2b_fv",  32'(ifA.validE),  0);
      chk("mb2b_fs",  32'(ifA.stall_o), 0);

      // Illegal opcode, then stall+flush together
      drive(1'b1, 7'b1111111, 3'd0, 7'd0, 5'd3);
      tick();
      chk("ill_flag",   32'(ifA.illegalE),  1);
      chk("ill_valid",  32'(ifA.validE),    1);
      chk("ill_rw",     32'(ifA.RegWriteE), 0);
      chk("ill_mw",     32'(ifA.MemWriteE), 0);
      chk("ill_pcb",    32'(ifA.PCBranchE), 0);
      chk("ill_immSel", 32'(ifA.immSelE),   6);
      drive(1'b1, 7'b0010011, 3'd0, 7'd0, 5'd5);
      stallIn = 1'b1;
      flushIn = 1'b1;
      tick();
      stallIn = 1'b0;
      flushIn = 1'b0;
      chk("sf_valid",  32'(ifA.validE),   0);
      chk("sf_ill",    32'(ifA.illegalE), 0);
      chk("sf_jalr",   32'(ifA.JALRctrlE), 1);
      chk("sf_immSel", 32'(ifA.immSelE),  6);
      chk("sf_srcA",   32'(ifA.SrcASelE), 3);

      // Reset asserted mid-BUSY
      drive(1'b1, 7'b0110011, 3'd0, 7'b0000001, 5'd12);
      tick();
      chk("rb_st", 32'(ifA.stall_o), 1);
      idle();
      #2;
      rst = 1'b1;
      #1;
      chk("rb_st0",    32'(ifA.stall_o),         0);
      chk("rb_valid",  32'(ifA.validE),          0);
      chk("rb_rwpipe", 32'(ifA.regwrite_pipe_o), 0);
      chk("rb_rdpipe", 32'(ifA.rd_pipe_o),       0);
      #2;
      rst = 1'b0;
      tick();
      chk("rb_after_st", 32'(ifA.stall_o),   0);
      chk("rb_after_dn", 32'(ifA.md_done_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end
endmodule
